// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/collect front end for the combinational bf16 FPU.
// Accepts one request at a time over req_valid/req_ready, holds the operator
// and operands on the FPU for EXEC_CYCLES cycles, captures the result and
// queues {result, rd, is_int} in an in-order response FIFO toward writeback.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   req_valid_i / req_ready_o    request handshake
//   req_op_i, req_a_i, req_b_i   operation and operands (bf16 in [31:16])
//   req_mode_i, req_rd_i         conversion mode, destination register tag
//   flush_i                      kill in-flight op and queued responses
//   fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o  to FPU
//   fpu_result_i                 from FPU
//   rsp_valid_o / rsp_ready_i    response handshake (FIFO head)
//   rsp_result_o, rsp_rd_o, rsp_is_int_o  head payload
//   busy_o                       op in flight or responses pending

package fpu_issue_pkg;

  typedef enum logic [3:0] {
    FP_ALU_ADD   = 4'd0,
    FP_ALU_SUB   = 4'd1,
    FP_ALU_MUL   = 4'd2,
    FP_ALU_DIV   = 4'd3,
    FP_ALU_MIN   = 4'd4,
    FP_ALU_MAX   = 4'd5,
    FP_ALU_SGNJ  = 4'd6,
    FP_ALU_CMP   = 4'd7,
    FP_ALU_CLASS = 4'd8,
    FP_ALU_CVT   = 4'd9
  } fp_alu_op_e;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        is_int;
  } rsp_entry_t;

endpackage

module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  fp_alu_op_e  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [1:0]  req_mode_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output fp_alu_op_e  fpu_operator_o,
  output logic [31:0] fpu_operand_a_o,
  output logic [31:0] fpu_operand_b_o,
  output logic [1:0]  fpu_mode_o,
  input  logic [31:0] fpu_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_is_int_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W  = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam int unsigned PTR_W  = $clog2(RSP_DEPTH);
  localparam int unsigned FILL_W = $clog2(RSP_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(RSP_DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(RSP_DEPTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_q;
  logic              is_int_q;

  rsp_entry_t        mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] count_q;

  logic accept, capture, pop, exec_done, req_is_int;
  rsp_entry_t head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Results that land in the integer regfile
  always_comb begin
    req_is_int = 1'b0;
    case (req_op_i)
      FP_ALU_CLASS, FP_ALU_CMP: req_is_int = 1'b1;
      FP_ALU_CVT:               req_is_int = !req_mode_i[1];
      default:                  req_is_int = 1'b0;
    endcase
  end

  // Issue FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshake and capture decode; flush overrides everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    exec_done   = (state_q == EXEC) && (cnt_q == '0);

    case (state_q)
      IDLE:    req_ready_o = (count_q < FILL_FULL);
      // A back-to-back accept coincides with a push, so one extra slot is needed
      EXEC:    req_ready_o = (cnt_q == '0) && (count_q < FILL_LAST);
      default: req_ready_o = 1'b0;
    endcase
    if (flush_i || rst_i) req_ready_o = 1'b0;

    accept  = req_valid_i && req_ready_o;
    capture = exec_done && !flush_i;

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = EXEC;
      cnt_d   = CNT_INIT;
    end else if (exec_done) begin
      state_d = IDLE;
    end else if (state_q == EXEC) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // FPU operand/operator registers and per-op tags, loaded on accept only
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fpu_operator_o  <= FP_ALU_ADD;
      fpu_operand_a_o <= '0;
      fpu_operand_b_o <= '0;
      fpu_mode_o      <= '0;
      rd_q            <= '0;
      is_int_q        <= 1'b0;
    end else if (accept) begin
      fpu_operator_o  <= req_op_i;
      fpu_operand_a_o <= req_a_i;
      fpu_operand_b_o <= req_b_i;
      fpu_mode_o      <= req_mode_i;
      rd_q            <= req_rd_i;
      is_int_q        <= req_is_int;
    end
  end

  assign pop = (count_q != '0) && rsp_ready_i;

  // Response FIFO (circular buffer)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (capture) begin
        mem_q[wr_ptr_q] <= '{result: fpu_result_i, rd: rd_q, is_int: is_int_q};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (capture && !pop)      count_q <= count_q + FILL_W'(1);
      else if (!capture && pop) count_q <= count_q - FILL_W'(1);
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign rsp_valid_o  = (count_q != '0);
  assign rsp_result_o = head.result;
  assign rsp_rd_o     = head.rd;
  assign rsp_is_int_o = head.is_int;
  assign busy_o       = (state_q == EXEC) || (count_q != '0);

  // The accept guard must make a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                  !(capture && (count_q == FILL_FULL)));

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequential front end that issues bfloat16 FP operations to the combinational FPU datapath and collects its results. It accepts one request at a time from the decode/ID side over a valid/ready handshake. It holds the FPU operand/operator registers stable for EXEC_CYCLES cycles, captures the FPU result, and queues responses in an in-order FIFO toward writeback. It is the requester/consumer end of the FPU operator/operand/result interface.

Parameters:
EXEC_CYCLES, 1, cycles operands are held on the FPU before the result is captured (>=1)
RSP_DEPTH, 2, response FIFO entries (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_op_i  in  fp_alu_op_e  operation
req_a_i  in  32  operand A (bf16 in [31:16])
req_b_i  in  32  operand B
req_mode_i  in  2  conversion mode
req_rd_i  in  5  destination register tag
flush_i  in  1  kill in-flight op and queued responses
fpu_operator_o  out  fp_alu_op_e  to FPU operator_i
fpu_operand_a_o  out  32  to FPU operand_a_i
fpu_operand_b_o  out  32  to FPU operand_b_i
fpu_mode_o  out  2  to FPU mode_i
fpu_result_i  in  32  from FPU result_o
rsp_valid_o  out  1  FIFO head valid
rsp_ready_i  in  1  writeback accepts head
rsp_result_o  out  32  head result
rsp_rd_o  out  5  head destination tag
rsp_is_int_o  out  1  head targets integer regfile
busy_o  out  1  op in flight or FIFO non-empty

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE; counter 0; FIFO empty; rd/is_int latches 0.
  - fpu_operator_o=FP_ALU_ADD; fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o = 0.
  - req_ready_o=0 while rst_i is high; rsp_valid_o=0; busy_o=0.
  - Reset mid-operation discards everything. No response is emitted.
- States:
  - IDLE: nothing in flight.
  - EXEC: operands are driving the FPU; down-counter cnt.
- Accept: on a rising edge with req_valid_i&&req_ready_o:
  - Load the fpu_* registers from req_*.
  - Latch req_rd_i and is_int.
  - Set cnt=EXEC_CYCLES-1 and enter EXEC.
- is_int=1 for FP_ALU_CLASS, FP_ALU_CMP, and FP_ALU_CVT with req_mode_i[1]=0. Otherwise 0.
- req_ready_o = !flush_i && ((IDLE && count<RSP_DEPTH) || (EXEC && cnt==0 && count<RSP_DEPTH-1)).
  - With EXEC_CYCLES=1 and writeback always ready, throughput is one op per cycle.
- EXEC, cnt!=0: decrement cnt each cycle. fpu_* outputs are held unchanged.
- EXEC, cnt==0: on that edge, push {fpu_result_i, rd, is_int} into the FIFO.
  - If a new request is accepted on the same edge, stay in EXEC with the new operands.
  - Otherwise go to IDLE.
- Latency: accept at edge N; capture at edge N+EXEC_CYCLES. With the FIFO empty, rsp_valid_o rises in the cycle after edge N+EXEC_CYCLES.
- FIFO:
  - Circular buffer with read/write pointers wrapping at RSP_DEPTH-1 and a count of width $clog2(RSP_DEPTH+1).
  - The head drives rsp_* combinationally. rsp_valid_o = (count!=0).
  - Pop on rsp_valid_o&&rsp_ready_i.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
  - The accept guard prevents a push when full. A push when full is an assertion failure.
- rsp_result_o is fpu_result_i exactly as captured, with no reformatting. The bf16 result is in [31:16] with [15:0]=0 for bf16 ops; integer results are full 32 bits.
- Flush: flush_i=1 at an edge clears FIFO (count=0, pointers=0), forces IDLE, and suppresses any capture or accept on that edge. fpu_* registers keep their values. flush_i has priority over every other event.
- busy_o = (state==EXEC) || (count!=0).
- While IDLE, fpu_* outputs hold the last issued op, since the FPU is combinational and its result is ignored.

Test Plan:
1. EXEC_CYCLES=1: ADD a=0x3F800000, b=0x40000000, rsp_ready_i=1 -> rsp_valid_o rises one cycle after accept with rsp_result_o=0x40400000 and rsp_is_int_o=0; busy_o returns 0 one cycle later.
2. EXEC_CYCLES=3: SUB a=0x40400000, b=0x3F800000, rd=7 -> fpu_operand_b_o stable for 3 cycles; req_ready_o=0 for the first 2 of those; response 0x40000000 with rsp_rd_o=7.
3. Back-to-back: three MULs (0x40000000*0x40400000, 0x3F800000*0x3F800000, 0xC0000000*0x40000000) with rsp_ready_i=0 -> FIFO fills with 0x40C00000, 0x3F800000; req_ready_o=0 until the first pop; the third result 0xC0800000 arrives in order after rsp_ready_i goes high.
4. CLASS on 0x7F800000 and CVT with mode=2'b00 -> rsp_is_int_o=1 for both; CVT with mode=2'b10 -> rsp_is_int_o=0.
5. Flush asserted in the same cycle as both a capture and a new req_valid_i, with one entry queued -> next cycle rsp_valid_o=0, busy_o=0, state IDLE, new request not accepted.
6. rst_i pulsed asynchronously mid-EXEC with 2 queued entries -> all outputs return to reset values immediately, and no response appears after release.
